// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sharing one W-bit JK flip-flop bank; grant->J/K drive (1 clk)->done (1 clk)->idle.
// Optional no-op error pulse on done enabled by JK_BANK_ERR_EN; requesters hold req until done.
module jk_bank_arbiter #(
   parameter int W    = 4,
   parameter int NREQ = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NREQ-1:0]     req,
   input  logic [2*NREQ-1:0]   cmd,
   input  logic [W*NREQ-1:0]   mask,
   output logic [NREQ-1:0]     gnt,
   output logic                done,
   output logic [W-1:0]        j,
   output logic [W-1:0]        k,
   output logic [W-1:0]        q_shadow,
   output logic                busy
`ifdef JK_BANK_ERR_EN
   ,
   output logic                err
`endif
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      ACK   = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [PW-1:0]   ptr, ptr_nxt;
   logic [PW-1:0]   sel_idx, sel_idx_nxt;
   logic [PW-1:0]   win_idx;
   logic            win_vld;
   logic [1:0]      win_cmd;
   logic [W-1:0]    win_mask;
   logic [NREQ-1:0] gnt_nxt;
   logic            done_nxt;
   logic [W-1:0]    j_nxt, k_nxt, q_nxt;
`ifdef JK_BANK_ERR_EN
   logic            noop_q, noop_nxt;
   logic            err_nxt;
`endif

   // Search starts at the pointer and wraps explicitly so non-power-of-two NREQ works.
   always_comb begin
      int cand;
      cand     = 0;
      win_vld  = 1'b0;
      win_idx  = '0;
      for (int off = 0; off < NREQ; off++) begin
         cand = int'(ptr) + off;
         if (cand >= NREQ) cand = cand - NREQ;
         if (!win_vld && req[cand]) begin
            win_vld = 1'b1;
            win_idx = PW'(cand);
         end
      end
      win_cmd  = cmd[2*int'(win_idx) +: 2];
      win_mask = mask[W*int'(win_idx) +: W];
   end

   always_comb begin
      state_nxt   = state;
      gnt_nxt     = gnt;
      done_nxt    = 1'b0;
      j_nxt       = '0;
      k_nxt       = '0;
      q_nxt       = q_shadow;
      ptr_nxt     = ptr;
      sel_idx_nxt = sel_idx;
`ifdef JK_BANK_ERR_EN
      noop_nxt    = noop_q;
      err_nxt     = 1'b0;
`endif
      case (state)
         IDLE: begin
            gnt_nxt = '0;
            if (win_vld) begin
               state_nxt        = DRIVE;
               gnt_nxt[win_idx] = 1'b1;
               sel_idx_nxt      = win_idx;
               // cmd[1] drives J and cmd[0] drives K, gated per bit by the mask.
               j_nxt            = win_mask & {W{win_cmd[1]}};
               k_nxt            = win_mask & {W{win_cmd[0]}};
`ifdef JK_BANK_ERR_EN
               noop_nxt         = (win_cmd == 2'b00) || (win_mask == '0);
`endif
            end
         end
         DRIVE: begin
            state_nxt = ACK;
            done_nxt  = 1'b1;
            q_nxt     = (j & ~q_shadow) | (~k & q_shadow);
            ptr_nxt   = (int'(sel_idx) == NREQ - 1) ? '0 : sel_idx + 1'b1;
`ifdef JK_BANK_ERR_EN
            err_nxt   = noop_q;
`endif
         end
         ACK: begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
         end
         default: begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         gnt      <= '0;
         done     <= 1'b0;
         j        <= '0;
         k        <= '0;
         q_shadow <= '0;
         ptr      <= '0;
         sel_idx  <= '0;
`ifdef JK_BANK_ERR_EN
         noop_q   <= 1'b0;
         err      <= 1'b0;
`endif
      end else begin
         state    <= state_nxt;
         gnt      <= gnt_nxt;
         done     <= done_nxt;
         j        <= j_nxt;
         k        <= k_nxt;
         q_shadow <= q_nxt;
         ptr      <= ptr_nxt;
         sel_idx  <= sel_idx_nxt;
`ifdef JK_BANK_ERR_EN
         noop_q   <= noop_nxt;
         err      <= err_nxt;
`endif
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Bench for jk_bank_arbiter: vector table plus hand sequences, checked through a done-driven scoreboard.
module tb_jk_bank_arbiter;

   logic        clk;
   logic        reset;
   logic [3:0]  req;
   logic [7:0]  cmd;
   logic [15:0] mask;
   logic [3:0]  gnt;
   logic        done;
   logic [3:0]  j, k, q_shadow;
   logic        busy;
`ifdef JK_BANK_ERR_EN
   logic        err;
`endif

   jk_bank_arbiter #(.W(4), .NREQ(4)) dut (
      .clk(clk), .reset(reset), .req(req), .cmd(cmd), .mask(mask),
      .gnt(gnt), .done(done), .j(j), .k(k), .q_shadow(q_shadow), .busy(busy)
`ifdef JK_BANK_ERR_EN
      , .err(err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         idx;
      logic [1:0] c;
      logic [3:0] m;
      logic [3:0] gnt;
      logic [3:0] j;
      logic [3:0] k;
      logic [3:0] q;
      logic       err;
   } vec_t;

   typedef struct {
      logic [3:0] gnt;
      logic [3:0] j;
      logic [3:0] k;
      logic [3:0] q;
      logic       err;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Model of the external flip-flop bank driven by j/k.
   logic [3:0] bank_q;
   always @(posedge clk) begin
      if (reset) bank_q <= 4'b0000;
      else       bank_q <= (j & ~bank_q) | (~k & bank_q);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
   endtask

   function automatic vec_t mk(int idx, logic [1:0] c, logic [3:0] m, logic [3:0] g,
                               logic [3:0] jj, logic [3:0] kk, logic [3:0] qq, logic e);
      vec_t v;
      v.idx = idx; v.c = c; v.m = m; v.gnt = g; v.j = jj; v.k = kk; v.q = qq; v.err = e;
      return v;
   endfunction

   function automatic exp_t mkx(logic [3:0] g, logic [3:0] jj, logic [3:0] kk, logic [3:0] qq, logic e);
      exp_t x;
      x.gnt = g; x.j = jj; x.k = kk; x.q = qq; x.err = e;
      return x;
   endfunction

   // Scoreboard: every done pulse pops one expectation.
   logic [3:0] prev_j, prev_k;
   always @(negedge clk) begin
      exp_t e;
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got done=1 expected no pulse");
         end else begin
            e = sb.pop_front();
            chk("ack_gnt", {28'd0, gnt}, {28'd0, e.gnt});
            chk("drive_j", {28'd0, prev_j}, {28'd0, e.j});
            chk("drive_k", {28'd0, prev_k}, {28'd0, e.k});
            chk("ack_jk_zero", {24'd0, j, k}, 32'd0);
            chk("ack_q_shadow", {28'd0, q_shadow}, {28'd0, e.q});
            chk("ack_bank_q", {28'd0, bank_q}, {28'd0, e.q});
`ifdef JK_BANK_ERR_EN
            chk("ack_err", {31'd0, err}, {31'd0, e.err});
`endif
         end
      end
      prev_j = j;
      prev_k = k;
   end

   task automatic wait_done(output int cyc);
      cyc = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         cyc++;
         if (done === 1'b1) return;
      end
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done after %0d cycles expected a pulse", cyc);
   endtask

   vec_t vt[9];

   initial begin
      int cyc;
      vt[0] = mk(0, 2'b10, 4'b0101, 4'b0001, 4'b0101, 4'b0000, 4'b0101, 1'b0);
      vt[1] = mk(1, 2'b11, 4'b1111, 4'b0010, 4'b1111, 4'b1111, 4'b1010, 1'b0);
      vt[2] = mk(1, 2'b01, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b1000, 1'b0);
      vt[3] = mk(2, 2'b00, 4'b1111, 4'b0100, 4'b0000, 4'b0000, 4'b1000, 1'b1);
      vt[4] = mk(3, 2'b10, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 1'b1);
      vt[5] = mk(3, 2'b11, 4'b0011, 4'b1000, 4'b0011, 4'b0011, 4'b1011, 1'b0);
      vt[6] = mk(2, 2'b01, 4'b1001, 4'b0100, 4'b0000, 4'b1001, 4'b0010, 1'b0);
      vt[7] = mk(0, 2'b11, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0010, 1'b1);
      vt[8] = mk(0, 2'b10, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0011, 1'b0);

      // Reset then idle.
      reset = 1'b1; req = '0; cmd = '0; mask = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_gnt", {28'd0, gnt}, 32'd0);
      chk("rst_jk", {24'd0, j, k}, 32'd0);
      chk("rst_q_shadow", {28'd0, q_shadow}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         chk("idle_done", {31'd0, done}, 32'd0);
      end

      // Single-requester commands from the table.
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         req = '0; cmd = '0; mask = '0;
         req[vt[i].idx]            = 1'b1;
         cmd[2*vt[i].idx +: 2]     = vt[i].c;
         mask[4*vt[i].idx +: 4]    = vt[i].m;
         sb.push_back(mkx(vt[i].gnt, vt[i].j, vt[i].k, vt[i].q, vt[i].err));
         wait_done(cyc);
         chk("latency", cyc, 2);
         req = '0;
         @(negedge clk);
         chk("post_ack_gnt", {28'd0, gnt}, 32'd0);
         chk("post_ack_busy", {31'd0, busy}, 32'd0);
      end

      // Latched cmd/mask survive input changes and req dropping after the grant.
      @(negedge clk);
      req = 4'b0001; cmd = 8'h02; mask = 16'h0004;
      sb.push_back(mkx(4'b0001, 4'b0100, 4'b0000, 4'b0111, 1'b0));
      @(negedge clk);
      chk("drive_busy", {31'd0, busy}, 32'd1);
      req = '0; cmd = 8'h01; mask = 16'h000F;
      wait_done(cyc);
      chk("drop_latency", cyc, 1);

      // Reset mid-command: pointer sits at 1, so the first grant goes to req1.
      @(negedge clk);
      @(negedge clk);
      req  = 4'b1111;
      cmd  = 8'hFF;
      mask = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
      @(negedge clk);
      chk("rr_ptr_gnt", {28'd0, gnt}, 32'h2);
      chk("rr_ptr_j", {28'd0, j}, 32'h2);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_jk", {24'd0, j, k}, 32'd0);
      chk("midrst_gnt", {28'd0, gnt}, 32'd0);
      chk("midrst_done", {31'd0, done}, 32'd0);
      chk("midrst_q_shadow", {28'd0, q_shadow}, 32'd0);

      // All requesting: grants cycle 0,1,2,3,0 starting from req0 after reset.
      sb.push_back(mkx(4'b0001, 4'b0001, 4'b0001, 4'b0001, 1'b0));
      sb.push_back(mkx(4'b0010, 4'b0010, 4'b0010, 4'b0011, 1'b0));
      sb.push_back(mkx(4'b0100, 4'b0100, 4'b0100, 4'b0111, 1'b0));
      sb.push_back(mkx(4'b1000, 4'b1000, 4'b1000, 4'b1111, 1'b0));
      sb.push_back(mkx(4'b0001, 4'b0001, 4'b0001, 4'b1110, 1'b0));
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         wait_done(cyc);
         chk("rr_period", cyc, (i == 0) ? 2 : 3);
      end
      req = '0;
      repeat (3) @(negedge clk);
      chk("sb_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
